// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Purpose  : shared types and default latencies for the hazard scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_scoreboard_pkg;

  localparam int HZ_REG_AW      = 5;
  localparam int HZ_ALU_LAT     = 3;
  localparam int HZ_LD_LAT      = 4;
  localparam int HZ_KILL_THRESH = 2;

  typedef logic [HZ_REG_AW-1:0]             regsel_t;
  typedef logic [$clog2(HZ_LD_LAT+1)-1:0]   lat_t;

  // Per-edge action chosen for one countdown cell
  typedef enum logic [1:0] {
    CNT_DEC  = 2'd0,
    CNT_HOLD = 2'd1,
    CNT_KILL = 2'd2,
    CNT_SET  = 2'd3
  } cnt_op_e;

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_count_cell.sv
// ============================================================================
// Module   : hz_count_cell
// Purpose  : one register's in-flight countdown: set, hold, decrement, kill
// Revision : 1.0
// ============================================================================
`default_nettype none

module hz_count_cell
  import hazard_scoreboard_pkg::*;
#(
  parameter int CW          = 3,
  parameter int KILL_THRESH = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          set_en,
  input  logic [CW-1:0] set_val,
  input  logic          mem_wait,
  input  logic          flush,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  cnt_op_e       op;

  // A new issue wins; younger entries die on flush; survivors freeze during a memory wait
  always_comb begin
    op = CNT_DEC;
    if (set_en) begin
      op = CNT_SET;
    end else if (flush && (int'(count_q) >= KILL_THRESH)) begin
      op = CNT_KILL;
    end else if (mem_wait) begin
      op = CNT_HOLD;
    end

    count_d = count_q;
    case (op)
      CNT_SET:  count_d = set_val;
      CNT_KILL: count_d = '0;
      CNT_HOLD: count_d = count_q;
      default:  if (count_q != '0) count_d = count_q - CW'(1);
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : per-register countdown scoreboard raising RAW/WAW decode stalls;
//            HAZARD_SCOREBOARD_STATS_EN adds stall/flush event counters
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW      = HZ_REG_AW,
  parameter int ALU_LAT     = HZ_ALU_LAT,
  parameter int LD_LAT      = HZ_LD_LAT,
  parameter int KILL_THRESH = HZ_KILL_THRESH,
  parameter int BYPASS      = 0,
  parameter int NREGS       = 2**REG_AW
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] rsel1,
  input  logic [REG_AW-1:0] rsel2,
  input  logic [REG_AW-1:0] wsel,
  input  logic              wen,
  input  logic              is_load,
  input  logic              mem_wait,
  input  logic              flush,
  output logic              hazard,
  output logic              issue_ok,
`ifdef HAZARD_SCOREBOARD_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic [NREGS-1:0]  busy
);

  localparam int CW = $clog2(LD_LAT+1);

  logic [CW-1:0] cnt [NREGS];
  logic          rd_busy1;
  logic          rd_busy2;
  logic          waw;

  function automatic logic rd_busy(input logic [REG_AW-1:0] x, input logic [CW-1:0] c);
    if (x == '0) return 1'b0;
    return (BYPASS != 0) ? (int'(c) > 1) : (c != '0);
  endfunction

  assign cnt[0] = '0;

  generate
    for (genvar r = 1; r < NREGS; r++) begin : g_cell
      hz_count_cell #(
        .CW          (CW),
        .KILL_THRESH (KILL_THRESH)
      ) u_cell (
        .CLK      (CLK),
        .nRST     (nRST),
        .set_en   (issue_ok && wen && (wsel == REG_AW'(r))),
        .set_val  (is_load ? CW'(LD_LAT) : CW'(ALU_LAT)),
        .mem_wait (mem_wait),
        .flush    (flush),
        .count    (cnt[r])
      );
    end
  endgenerate

  always_comb begin
    rd_busy1 = rd_busy(rsel1, cnt[rsel1]);
    rd_busy2 = rd_busy(rsel2, cnt[rsel2]);
    // A pending write to the same destination must retire first, so a set never meets a live count
    waw      = wen && (wsel != '0) && (cnt[wsel] != '0);
    hazard   = issue_valid && (mem_wait || rd_busy1 || rd_busy2 || waw);
    issue_ok = issue_valid && !hazard && !flush;
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, hazard};
    flush_cnt_d = flush_cnt_q + {15'd0, flush};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : directed self-checking bench for hazard_scoreboard (plain and bypass)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  localparam int NREGS = 32;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       issue_valid, wen, is_load, mem_wait, flush;
  logic [4:0] rsel1, rsel2, wsel;

  logic             hazard, issue_ok, hazard_bp, issue_ok_bp;
  logic [NREGS-1:0] busy, busy_bp;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt, stall_cnt_bp;
  logic [15:0] flush_cnt, flush_cnt_bp;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.BYPASS(0)) dut (
    .CLK(clk), .nRST(n_rst), .issue_valid(issue_valid), .rsel1(rsel1), .rsel2(rsel2),
    .wsel(wsel), .wen(wen), .is_load(is_load), .mem_wait(mem_wait), .flush(flush),
    .hazard(hazard), .issue_ok(issue_ok),
`ifdef HAZARD_SCOREBOARD_STATS_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .busy(busy)
  );

  hazard_scoreboard #(.BYPASS(1)) dut_bp (
    .CLK(clk), .nRST(n_rst), .issue_valid(issue_valid), .rsel1(rsel1), .rsel2(rsel2),
    .wsel(wsel), .wen(wen), .is_load(is_load), .mem_wait(mem_wait), .flush(flush),
    .hazard(hazard_bp), .issue_ok(issue_ok_bp),
`ifdef HAZARD_SCOREBOARD_STATS_EN
    .stall_cnt(stall_cnt_bp), .flush_cnt(flush_cnt_bp),
`endif
    .busy(busy_bp)
  );

  task automatic idle();
    issue_valid = 1'b0; wen = 1'b0; is_load = 1'b0; mem_wait = 1'b0; flush = 1'b0;
    rsel1 = '0; rsel2 = '0; wsel = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_write(input logic [4:0] dst, input logic ld);
    idle();
    issue_valid = 1'b1; wen = 1'b1; wsel = dst; is_load = ld;
  endtask

  task automatic do_reset();
    idle();
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    issue_write(5'd3, 1'b0);
    step();
    idle();
    @(negedge clk);
    vectors++;
    if (busy !== 32'h0000_0008) begin
      miscompares++;
      $display("FAIL reset_pre busy got %h want %h", busy, 32'h0000_0008);
    end
    n_rst = 1'b0;
    #1;
    vectors++;
    if (busy !== '0) begin
      miscompares++;
      $display("FAIL reset_async busy got %h want 0", busy);
    end
    #1;
    n_rst = 1'b1;
    issue_valid = 1'b1; mem_wait = 1'b1;
    #1;
    issue_valid = 1'b0;
    #1;
    vectors++;
    if (hazard !== 1'b0 || issue_ok !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_novalid hazard/issue_ok got %b%b want 00", hazard, issue_ok);
    end
    step();
    idle();
    issue_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (hazard !== 1'b0 || issue_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_r0 hazard/issue_ok got %b%b want 01", hazard, issue_ok);
    end
    step();
  endtask

  task automatic test_raw();
    do_reset();
    issue_write(5'd5, 1'b0);
    @(negedge clk);
    vectors++;
    if (issue_ok !== 1'b1 || issue_ok_bp !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_issue issue_ok got %b/%b want 1/1", issue_ok, issue_ok_bp);
    end
    step();
    idle();
    issue_valid = 1'b1; rsel1 = 5'd5;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      vectors++;
      if (hazard !== (c <= 3) || issue_ok !== (c == 4)) begin
        miscompares++;
        $display("FAIL raw_c%0d hazard/issue_ok got %b%b want %b%b", c, hazard, issue_ok, c <= 3, c == 4);
      end
      vectors++;
      if (hazard_bp !== (c <= 2)) begin
        miscompares++;
        $display("FAIL raw_bypass_c%0d hazard got %b want %b", c, hazard_bp, c <= 2);
      end
      step();
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    issue_write(5'd8, 1'b1);
    step();
    idle();
    issue_valid = 1'b1; rsel2 = 5'd8;
    for (int c = 1; c <= 7; c++) begin
      mem_wait = (c == 2 || c == 3);
      @(negedge clk);
      vectors++;
      if (hazard !== (c <= 6) || issue_ok !== (c == 7) || busy[8] !== (c <= 6)) begin
        miscompares++;
        $display("FAIL load_c%0d hazard/issue_ok/busy8 got %b%b%b want %b%b%b",
                 c, hazard, issue_ok, busy[8], c <= 6, c == 7, c <= 6);
      end
      step();
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue_write(5'd6, 1'b0);
    step();
    idle();
    step();
    issue_write(5'd5, 1'b0);
    @(negedge clk);
    vectors++;
    if (issue_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_setup issue_ok got %b want 1", issue_ok);
    end
    step();
    issue_write(5'd9, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (issue_ok !== 1'b0 || hazard !== 1'b0 || busy !== 32'h0000_0060) begin
      miscompares++;
      $display("FAIL flush_cycle issue_ok/hazard/busy got %b%b %h want 00 00000060", issue_ok, hazard, busy);
    end
    step();
    idle();
    @(negedge clk);
    vectors++;
    if (busy !== '0) begin
      miscompares++;
      $display("FAIL flush_after busy got %h want 0", busy);
    end
    // a count-1 survivor of a flush during a memory wait must freeze, not retire
    issue_write(5'd10, 1'b0);
    step();
    idle();
    step();
    step();
    flush = 1'b1; mem_wait = 1'b1;
    step();
    idle();
    @(negedge clk);
    vectors++;
    if (busy !== 32'h0000_0400) begin
      miscompares++;
      $display("FAIL flush_wait_hold busy got %h want 00000400", busy);
    end
    step();
    @(negedge clk);
    vectors++;
    if (busy !== '0) begin
      miscompares++;
      $display("FAIL flush_wait_retire busy got %h want 0", busy);
    end
    step();
  endtask

  task automatic test_waw();
    do_reset();
    issue_write(5'd7, 1'b0);
    step();
    issue_write(5'd7, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      vectors++;
      if (hazard !== (c <= 3) || issue_ok !== (c == 4) || busy[7] !== (c <= 3)) begin
        miscompares++;
        $display("FAIL waw_c%0d hazard/issue_ok/busy7 got %b%b%b want %b%b%b",
                 c, hazard, issue_ok, busy[7], c <= 3, c == 4, c <= 3);
      end
      step();
    end
    idle();
    @(negedge clk);
    vectors++;
    if (busy !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL waw_reissue busy got %h want 00000080", busy);
    end
    do_reset();
    issue_write(5'd0, 1'b1);
    @(negedge clk);
    vectors++;
    if (hazard !== 1'b0 || issue_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL r0_write hazard/issue_ok got %b%b want 01", hazard, issue_ok);
    end
    step();
    idle();
    @(negedge clk);
    vectors++;
    if (busy !== '0) begin
      miscompares++;
      $display("FAIL r0_untracked busy got %h want 0", busy);
    end
    step();
  endtask

`ifdef HAZARD_SCOREBOARD_STATS_EN
  task automatic test_stats();
    do_reset();
    issue_valid = 1'b1; mem_wait = 1'b1;
    repeat (5) step();
    idle();
    flush = 1'b1;
    repeat (2) step();
    idle();
    @(negedge clk);
    vectors++;
    if (stall_cnt !== 32'd5 || flush_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL stats stall/flush got %0d/%0d want 5/2", stall_cnt, flush_cnt);
    end
    step();
  endtask
`endif

  initial begin
    idle();
    n_rst = 1'b0;
    #12;
    test_reset();
    test_raw();
    test_load_wait();
    test_flush();
    test_waw();
`ifdef HAZARD_SCOREBOARD_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
